// File: rtl/alu_pkg.sv
// Shared op-code and FSM-state encodings for multicycle_alu and its iterative datapath.
package alu_pkg;

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpNor   = 4'b1100;
    localparam logic [3:0] OpMult  = 4'b1000;
    localparam logic [3:0] OpMultu = 4'b1001;
    localparam logic [3:0] OpDiv   = 4'b1010;
    localparam logic [3:0] OpDivu  = 4'b1011;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// Operates on magnitudes; signs are re-applied on the final step.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, shifted;
    logic [WIDTH-1:0] rem_sub, hi_step, lo_step;
    logic [2*WIDTH-1:0] prod;

    assign done_o = busy_q && (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        a_neg   = is_signed_i & a_i[WIDTH-1];
        b_neg   = is_signed_i & b_i[WIDTH-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;

        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        rem_sub = WIDTH'(shifted - {1'b0, mcand_q});
        if (is_div_q) begin
            if (shifted >= {1'b0, mcand_q}) begin
                hi_step = rem_sub;
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = shifted[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step = add_sum[WIDTH:1];
            lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
        end

        prod = {hi_step, lo_step};
        if (neg_q) begin
            prod = -prod;
        end
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
        if (is_div_q) begin
            lo_o = neg_q ? -lo_step : lo_step;
            hi_o = rem_neg_q ? -hi_step : hi_step;
            // Divide by zero reports the raw dividend rather than the shifted magnitude.
            if (dz_q) begin
                lo_o = '1;
                hi_o = dvd_q;
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        dvd_d     = dvd_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start_i) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = is_div_i;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = (b_i == '0);
            dvd_d     = a_i;
            hi_d      = '0;
            mcand_d   = is_div_i ? b_mag : a_mag;
            lo_d      = is_div_i ? a_mag : b_mag;
        end else if (busy_q) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + CntW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            dvd_q     <= dvd_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with valid/ready request and response handshakes.
// Define MULTICYCLE_ALU_MULDIV_EN to build the iterative mult/multu/div/divu datapath.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             illegal
);

    logic [1:0]       state_q, state_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             illegal_q, illegal_d;

    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo, alu_res;
    logic             alu_ill;

    // armed_q keeps in_ready low until the first clock edge after reset release.
    assign in_ready  = armed_q && (state_q == StIdle);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_op)
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpSlt:   alu_res = {{(WIDTH - 1){1'b0}}, $signed(a) < $signed(b)};
            OpNor:   alu_res = ~(a | b);
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef MULTICYCLE_ALU_MULDIV_EN
    assign md_start = accept && is_muldiv_op(alu_op);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (md_start),
        .is_div_i   (alu_op[1]),
        .is_signed_i(~alu_op[0]),
        .a_i        (a),
        .b_i        (b),
        .done_o     (md_done),
        .hi_o       (md_hi),
        .lo_o       (md_lo)
    );
`else
    assign md_start = 1'b0;
    assign md_done  = 1'b0;
    assign md_hi    = '0;
    assign md_lo    = '0;
`endif

    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b1;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (md_start) begin
                    state_d = alu_op[1] ? StDiv : StMul;
                end else if (accept) begin
                    state_d   = StDone;
                    result_d  = alu_res;
                    illegal_d = alu_ill;
                end
            end
            StMul, StDiv: begin
                if (md_done) begin
                    state_d   = StDone;
                    hi_d      = md_hi;
                    lo_d      = md_lo;
                    result_d  = md_lo;
                    illegal_d = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed scoreboard bench for multicycle_alu (WIDTH=32); adapts to MULTICYCLE_ALU_MULDIV_EN.
module tb_multicycle_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  a, b;
    logic [3:0]    alu_op;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  result, hi, lo;
    logic          zero, illegal;

    always #5 clk = ~clk;

    multicycle_alu #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .hi       (hi),
        .lo       (lo),
        .zero     (zero),
        .illegal  (illegal)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model; hi/lo persist across ops like the architectural registers.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                         output exp_t e);
        logic [63:0] p;
        bit          md;
        int          ix, iy;
        ix = x;
        iy = y;
        p  = '0;
        md = 1'b0;
        e  = '0;
        e.lat = 8'd1;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: e.res = x + y;
            4'b0110: e.res = x - y;
            4'b0111: e.res = (ix < iy) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(x | y);
`ifdef MULTICYCLE_ALU_MULDIV_EN
            4'b1000: begin
                md = 1'b1;
                p  = 64'(longint'(ix) * longint'(iy));
            end
            4'b1001: begin
                md = 1'b1;
                p  = {32'd0, x} * {32'd0, y};
            end
            4'b1010: begin
                md = 1'b1;
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else p = {32'(ix % iy), 32'(ix / iy)};
            end
            4'b1011: begin
                md = 1'b1;
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
`endif
            default: e.ill = 1'b1;
        endcase
        if (md) begin
            m_hi  = p[63:32];
            m_lo  = p[31:0];
            e.res = m_lo;
            e.lat = 8'(W + 1);
        end
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge after acceptance.
    task automatic issue(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] op);
        exp_t e;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        model(x, y, op, e);
        sb.push_back(e);
        a        = x;
        b        = y;
        alu_op   = op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_op   = 4'($urandom);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
        chk({tag, " result"}, 64'(result), 64'(e.res));
        chk({tag, " hi"}, 64'(hi), 64'(e.hi));
        chk({tag, " lo"}, 64'(lo), 64'(e.lo));
        chk({tag, " illegal"}, 64'(illegal), 64'(e.ill));
        chk({tag, " zero"}, 64'(zero), 64'(e.res == 32'd0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        chk("reset illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;
        chk("in_ready before first edge", 64'(in_ready), 64'd0);
        @(negedge clk);

        issue("add wrap", 32'hFFFF_FFFF, 32'd1, 4'b0010);        collect("add wrap");
        issue("and", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000);     collect("and");
        issue("or", 32'hA000_0005, 32'h0500_0A00, 4'b0001);      collect("or");
        issue("sub wrap", 32'd3, 32'd5, 4'b0110);                collect("sub wrap");
        issue("slt neg", 32'hFFFF_FFFF, 32'd1, 4'b0111);         collect("slt neg");
        issue("slt pos", 32'd1, 32'hFFFF_FFFF, 4'b0111);         collect("slt pos");
        issue("nor", 32'h0000_FFFF, 32'hFF00_0000, 4'b1100);     collect("nor");
        issue("mult", 32'hFFFF_FFFF, 32'd2, 4'b1000);            collect("mult");
        issue("add keeps hilo", 32'd40, 32'd2, 4'b0010);         collect("add keeps hilo");
        issue("multu", 32'hFFFF_FFFF, 32'd2, 4'b1001);           collect("multu");
        issue("div", 32'hFFFF_FFF9, 32'd2, 4'b1010);             collect("div");
        issue("divu by zero", 32'd7, 32'd0, 4'b1011);            collect("divu by zero");
        issue("div by zero", 32'hFFFF_FFF9, 32'd0, 4'b1010);     collect("div by zero");
        issue("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b1010); collect("div ovf");
        issue("divu", 32'hDEAD_BEEF, 32'd1000, 4'b1011);         collect("divu");
        issue("mult mixed", 32'd12345, 32'hFFFF_FF00, 4'b1000);  collect("mult mixed");
        issue("illegal 1111", 32'd5, 32'd6, 4'b1111);            collect("illegal 1111");
        issue("op 1000", 32'd3, 32'd4, 4'b1000);                 collect("op 1000");

        // Back-pressure: response held, new requests ignored.
        issue("bp or", 32'hF0F0_0000, 32'h0000_0F0F, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            alu_op   = 4'b0010;
            @(negedge clk);
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp result", 64'(result), 64'h0000_0000_F0F0_0F0F);
            chk("bp hi", 64'(hi), 64'(m_hi));
            chk("bp lo", 64'(lo), 64'(m_lo));
            chk("bp illegal", 64'(illegal), 64'd0);
        end
        in_valid = 1'b0;
        collect("bp or");
        @(negedge clk);
        chk("bp no extra response", 64'(out_valid), 64'd0);

        // Reset in the middle of a divide: no response, clean restart.
        issue("rst div", 32'd1000, 32'd7, 4'b1010);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst zero", 64'(zero), 64'd1);
        chk("rst illegal", 64'(illegal), 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst release in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst no response", 64'(out_valid), 64'd0);
        end
        issue("post-rst sub", 32'd10, 32'd3, 4'b0110);            collect("post-rst sub");
        issue("post-rst divu", 32'd100, 32'd9, 4'b1011);          collect("post-rst divu");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
